// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch PC sequencer: branch-control codes and FSM states.
package pc_seq_pkg;

    localparam logic [1:0] BC_PC4 = 2'd0;
    localparam logic [1:0] BC_IMM = 2'd1;
    localparam logic [1:0] BC_ALU = 2'd2;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_WAIT_REDIR = 2'd1,
        S_TRAP       = 2'd2
    } pc_seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch request bus between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    // A fetch transfers on a cycle where PC_Valid && IMem_Ready; while PC_Valid is
    // high and IMem_Ready is low, PC is held stable by the master.
    logic [XLEN-1:0] PC;
    logic            PC_Valid;
    logic            IMem_Ready;

    modport master (output PC, output PC_Valid, input IMem_Ready);
    modport slave  (input PC, input PC_Valid, output IMem_Ready);
endinterface

// File: rtl/branch_target_gen.sv
// Combinational redirect target select from EX, with JALR bit-0 clear and misalignment flag.
module branch_target_gen
    import pc_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      bc,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] target,
    output logic            is_jump,
    output logic            misaligned
);

    always_comb begin
        target  = ex_pc + XLEN'(4);
        is_jump = 1'b0;
        case (bc)
            BC_PC4: begin
                target  = ex_pc + XLEN'(4);
                is_jump = 1'b0;
            end
            BC_IMM: begin
                target  = ex_pc + ex_imm;
                is_jump = 1'b1;
            end
            BC_ALU: begin
                target  = alu_result & {{(XLEN-1){1'b1}}, 1'b0};
                is_jump = 1'b1;
            end
            default: begin
                target  = ex_pc + XLEN'(4);
                is_jump = 1'b0;
            end
        endcase
    end

    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and sequencer: PC+4 advance, stall hold, EX redirects, flushes, misaligned-target trap.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Stall,
    input  logic               EX_Valid,
    input  logic [1:0]         Branch_Control,
    input  logic [XLEN-1:0]    EX_PC,
    input  logic [XLEN-1:0]    EX_Imm,
    input  logic [XLEN-1:0]    ALU_Result,
    input  logic               Trap_Ack,
    pc_sequencer_if.master     fetch,
    output logic               Flush_IF_ID,
    output logic               Flush_ID_EX,
    output logic               Redirect,
    output logic               Trap_Req,
    output logic [XLEN-1:0]    Trap_EPC,
    output logic [XLEN-1:0]    Trap_Tval,
    output pc_seq_state_e      dbg_state
);

    pc_seq_state_e   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            pend_trap_q, pend_trap_d;
    logic [XLEN-1:0] epc_q, epc_d, tval_q, tval_d;
    logic [XLEN-1:0] target;
    logic            is_jump, misaligned, event_c, ready;

    branch_target_gen #(.XLEN(XLEN)) u_target (
        .bc         (Branch_Control),
        .ex_pc      (EX_PC),
        .ex_imm     (EX_Imm),
        .alu_result (ALU_Result),
        .target     (target),
        .is_jump    (is_jump),
        .misaligned (misaligned)
    );

    assign ready   = fetch.IMem_Ready;
    assign event_c = EX_Valid && is_jump;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            pend_trap_q <= 1'b0;
            epc_q       <= '0;
            tval_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_trap_q <= pend_trap_d;
            epc_q       <= epc_d;
            tval_q      <= tval_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_trap_d = pend_trap_q;
        epc_d       = epc_q;
        tval_d      = tval_q;
        fetch.PC_Valid = 1'b0;
        Flush_IF_ID = 1'b0;
        Flush_ID_EX = 1'b0;
        Redirect    = 1'b0;
        case (state_q)
            S_RUN: begin
                fetch.PC_Valid = 1'b1;
                if (event_c) begin
                    Flush_IF_ID = 1'b1;
                    Flush_ID_EX = 1'b1;
                    Redirect    = 1'b1;
                    if (misaligned) begin
                        epc_d       = EX_PC;
                        tval_d      = target;
                        pend_trap_d = 1'b1;
                        state_d     = ready ? S_TRAP : S_WAIT_REDIR;
                    end else if (ready) begin
                        pc_d = target;
                    end else begin
                        pend_d      = target;
                        pend_trap_d = 1'b0;
                        state_d     = S_WAIT_REDIR;
                    end
                end else if (!Stall && ready) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            S_WAIT_REDIR: begin
                fetch.PC_Valid = 1'b1;
                // The fetch returned now belongs to the squashed path, so IF/ID drops it.
                if (ready) begin
                    Flush_IF_ID = 1'b1;
                    pend_trap_d = 1'b0;
                    if (pend_trap_q) begin
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = pend_q;
                        state_d = S_RUN;
                    end
                end
            end
            S_TRAP: begin
                Flush_IF_ID = 1'b1;
                Flush_ID_EX = 1'b1;
                if (Trap_Ack) begin
                    pc_d    = TRAP_VEC;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
        if (rst) begin
            fetch.PC_Valid = 1'b0;
            Flush_IF_ID = 1'b0;
            Flush_ID_EX = 1'b0;
            Redirect    = 1'b0;
        end
    end

    assign fetch.PC  = pc_q;
    assign Trap_Req  = (state_q == S_TRAP) && !rst;
    assign Trap_EPC  = epc_q;
    assign Trap_Tval = tval_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle expectations queued by the driver, checked by a negedge monitor.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int W = 103;
    // expectation layout: [102] care_pc [101] care_trap [100:69] tval [68:37] epc [36:5] pc
    // [4:0] {PC_Valid, Flush_IF_ID, Flush_ID_EX, Redirect, Trap_Req}
    localparam logic [4:0] F_NONE  = 5'b00000;
    localparam logic [4:0] F_RUN   = 5'b10000;
    localparam logic [4:0] F_REDIR = 5'b11110;
    localparam logic [4:0] F_WEXIT = 5'b11000;
    localparam logic [4:0] F_TRAP  = 5'b01101;

    logic        clk = 1'b1;
    logic        rst;
    logic        stall, ex_valid, trap_ack;
    logic [1:0]  bc;
    logic [31:0] ex_pc, ex_imm, alu_result;
    logic        flush_if_id, flush_id_ex, redirect, trap_req;
    logic [31:0] trap_epc, trap_tval;
    pc_seq_state_e dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic [4:0]   got_f;
    int checks = 0;
    int failures = 0;
    int ncyc = 0;

    pc_sequencer_if #(.XLEN(32)) fetch_if ();

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .Stall          (stall),
        .EX_Valid       (ex_valid),
        .Branch_Control (bc),
        .EX_PC          (ex_pc),
        .EX_Imm         (ex_imm),
        .ALU_Result     (alu_result),
        .Trap_Ack       (trap_ack),
        .fetch          (fetch_if.master),
        .Flush_IF_ID    (flush_if_id),
        .Flush_ID_EX    (flush_id_ex),
        .Redirect       (redirect),
        .Trap_Req       (trap_req),
        .Trap_EPC       (trap_epc),
        .Trap_Tval      (trap_tval),
        .dbg_state      (dbg_state)
    );

    // clock: first negedge at 5, first posedge at 10
    initial forever #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; stall = 1'b0; ex_valid = 1'b0; bc = BC_PC4;
        ex_pc = '0; ex_imm = '0; alu_result = '0; trap_ack = 1'b0;
        fetch_if.IMem_Ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_full(input logic care_pc, input logic care_trap, input logic [4:0] f,
                            input logic [31:0] pc, input logic [31:0] epc, input logic [31:0] tval);
        exp_q.push_back({care_pc, care_trap, tval, epc, pc, f});
        tick();
    endtask

    task automatic cyc(input logic [4:0] f, input logic [31:0] pc);
        cyc_full(1'b1, 1'b0, f, pc, '0, '0);
    endtask

    task automatic cyc_t(input logic [4:0] f, input logic [31:0] pc, input logic [31:0] epc,
                         input logic [31:0] tval);
        cyc_full(1'b1, 1'b1, f, pc, epc, tval);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got_f = {fetch_if.PC_Valid, flush_if_id, flush_id_ex, redirect, trap_req};
            checks++;
            if (got_f !== e[4:0]) begin
                failures++;
                $display("FAIL flags cyc=%0d got=%b exp=%b (valid,fif,fidex,redir,trapreq)",
                         ncyc, got_f, e[4:0]);
            end
            if (e[102]) begin
                checks++;
                if (fetch_if.PC !== e[36:5]) begin
                    failures++;
                    $display("FAIL pc cyc=%0d got=%h exp=%h", ncyc, fetch_if.PC, e[36:5]);
                end
            end
            if (e[101]) begin
                checks++;
                if (trap_epc !== e[68:37] || trap_tval !== e[100:69]) begin
                    failures++;
                    $display("FAIL trap_regs cyc=%0d got epc=%h tval=%h exp epc=%h tval=%h",
                             ncyc, trap_epc, trap_tval, e[68:37], e[100:69]);
                end
            end
            ncyc++;
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        // reset: PC unknown in the first cycle, RESET_PC afterwards, all outputs quiet
        cyc_full(1'b0, 1'b0, F_NONE, '0, '0, '0);
        cyc(F_NONE, 32'h0);
        cyc(F_NONE, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(F_RUN, 32'(4 * i));
        // load-use stall at 0x20
        stall = 1'b1;
        cyc(F_RUN, 32'h20);
        cyc(F_RUN, 32'h20);
        stall = 1'b0;
        cyc(F_RUN, 32'h20);
        // branch back to 0x0 wins over stall
        ex_valid = 1'b1; bc = BC_IMM; ex_pc = 32'h10; ex_imm = 32'hFFFF_FFF0; stall = 1'b1;
        cyc(F_REDIR, 32'h24);
        idle();
        cyc(F_RUN, 32'h0);
        // JALR to 0x103 -> 0x102, misaligned, IMem busy
        ex_valid = 1'b1; bc = BC_ALU; alu_result = 32'h103; ex_pc = 32'h30;
        fetch_if.IMem_Ready = 1'b0;
        cyc(F_REDIR, 32'h4);
        cyc_t(F_RUN, 32'h4, 32'h30, 32'h102);
        fetch_if.IMem_Ready = 1'b1;
        cyc(F_WEXIT, 32'h4);
        idle();
        cyc_t(F_TRAP, 32'h4, 32'h30, 32'h102);
        trap_ack = 1'b1;
        cyc(F_TRAP, 32'h4);
        // Trap_Ack held into RUN has no effect
        cyc(F_RUN, 32'h100);
        // aligned branch to 0x40 with IMem busy; stall and EX_Valid ignored while waiting
        idle();
        ex_valid = 1'b1; bc = BC_IMM; ex_pc = 32'h20; ex_imm = 32'h20;
        fetch_if.IMem_Ready = 1'b0;
        cyc(F_REDIR, 32'h104);
        stall = 1'b1;
        cyc(F_RUN, 32'h104);
        cyc(F_RUN, 32'h104);
        fetch_if.IMem_Ready = 1'b1;
        cyc(F_WEXIT, 32'h104);
        idle();
        cyc(F_RUN, 32'h40);
        // misaligned branch with ready goes straight to TRAP, then reset inside TRAP
        ex_valid = 1'b1; bc = BC_IMM; ex_pc = 32'h50; ex_imm = 32'h2;
        cyc_t(F_REDIR, 32'h44, 32'h30, 32'h102);
        idle();
        cyc_t(F_TRAP, 32'h44, 32'h50, 32'h52);
        rst = 1'b1;
        cyc(F_NONE, 32'h44);
        rst = 1'b0;
        cyc_t(F_RUN, 32'h0, 32'h0, 32'h0);
        // reset inside WAIT_REDIR discards the pending target
        ex_valid = 1'b1; bc = BC_IMM; ex_pc = 32'h0; ex_imm = 32'h80;
        fetch_if.IMem_Ready = 1'b0;
        cyc(F_REDIR, 32'h4);
        idle();
        rst = 1'b1; fetch_if.IMem_Ready = 1'b0;
        cyc(F_NONE, 32'h4);
        rst = 1'b0; fetch_if.IMem_Ready = 1'b1;
        cyc(F_RUN, 32'h0);
        // reserved code and non-valid EX do not redirect
        ex_valid = 1'b1; bc = 2'd3; ex_imm = 32'h100;
        cyc(F_RUN, 32'h4);
        idle();
        bc = BC_IMM; ex_imm = 32'h100;
        cyc(F_RUN, 32'h8);
        // JALR bit-0 clear to aligned 0x200
        idle();
        ex_valid = 1'b1; bc = BC_ALU; alu_result = 32'h201;
        cyc(F_REDIR, 32'hC);
        // target wraps to 0xFFFF_FFFC, then PC+4 wraps to 0
        idle();
        ex_valid = 1'b1; bc = BC_IMM; ex_pc = 32'h0; ex_imm = 32'hFFFF_FFFC;
        cyc(F_REDIR, 32'h200);
        idle();
        cyc(F_RUN, 32'hFFFF_FFFC);
        cyc(F_RUN, 32'h0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
